// File: rtl/pathsy_fifo_pkg.sv
// Shared FIFO helpers: pointer increment and output-stage sizing.
// Used by bram_fifo_reader and fifo_out_stage.
package pathsy_fifo_pkg;

    localparam int FIFO_OUT_STAGE_DEPTH = 2;

    // Occupancy of the head/skid output stage (0..2).
    typedef logic [1:0] stage_count_t;

    // Modulo-depth increment; works for any depth, not only powers of two.
    function automatic logic [31:0] fifo_ptr_next(input logic [31:0] ptr,
                                                  input logic [31:0] depth);
        return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/bram_1r1w.sv
// Simple dual-port block RAM: one write port, one read port with a
// single-cycle registered read.
module bram_1r1w #(
    parameter int ADDR_WIDTH = 4,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [0:(1<<ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/fifo_out_stage.sv
// Two-entry head/skid register FIFO that hides the BRAM read latency.
// The caller guarantees it never loads into a full stage without a pop.
module fifo_out_stage
    import pathsy_fifo_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_valid,
    input  logic [WIDTH-1:0] load_data,
    input  logic             pop,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output stage_count_t     stage_count
);

    logic             head_valid, skid_valid;
    logic [WIDTH-1:0] head_data, skid_data;

    logic             head_valid_nxt, skid_valid_nxt;
    logic [WIDTH-1:0] head_data_nxt, skid_data_nxt;
    logic             head_valid_pop;

    // Apply the pop first (skid shifts into head), then drop the load
    // into the first free entry so pop and load can share one cycle.
    always_comb begin
        head_valid_pop = pop ? skid_valid : head_valid;
        head_valid_nxt = head_valid_pop;
        head_data_nxt  = pop ? skid_data : head_data;
        skid_valid_nxt = skid_valid & ~pop;
        skid_data_nxt  = skid_data;
        if (load_valid) begin
            if (!head_valid_pop) begin
                head_valid_nxt = 1'b1;
                head_data_nxt  = load_data;
            end else begin
                skid_valid_nxt = 1'b1;
                skid_data_nxt  = load_data;
            end
        end
    end

    // Data registers hold their value through reset so out_data stays stable.
    always_ff @(posedge clk) begin
        if (!reset) begin
            head_valid <= 1'b0;
            skid_valid <= 1'b0;
        end else begin
            head_valid <= head_valid_nxt;
            skid_valid <= skid_valid_nxt;
            head_data  <= head_data_nxt;
            skid_data  <= skid_data_nxt;
        end
    end

    assign valid       = head_valid;
    assign data        = head_data;
    assign stage_count = {1'b0, head_valid} + {1'b0, skid_valid};

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset)
        !(load_valid && skid_valid && !pop));

    a_skid_implies_head: assert property (@(posedge clk) disable iff (!reset)
        !(skid_valid && !head_valid));

endmodule

// File: rtl/bram_fifo_reader.sv
// Elastic BRAM-backed FIFO with a registered two-entry output stage.
// Optional first-word bypass into the output stage: BRAM_FIFO_BYPASS_EN.
module bram_fifo_reader
    import pathsy_fifo_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int DEPTH       = 16,
    parameter int COUNT_WIDTH = $clog2(DEPTH+3)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_data,
    output logic [COUNT_WIDTH-1:0] count
);

    localparam int AW  = $clog2(DEPTH);
    localparam int BCW = $clog2(DEPTH+1);

    // Handshakes: a word moves on a port exactly at a rising edge where
    // valid && ready; valid never waits on ready, and in_ready depends on
    // registered state only (never on out_ready).

    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [BCW-1:0]   bram_count;
    logic             rd_inflight;
    stage_count_t     stage_count;

    logic             accept, pop, issue, bypass, bram_we;
    logic [2:0]       occ_after_pop;
    logic             load_valid;
    logic [WIDTH-1:0] load_data, bram_rdata;

    assign in_ready = (bram_count != BCW'(DEPTH));
    assign accept   = in_valid && in_ready;
    assign pop      = out_valid && out_ready;

    // Stage slots already promised (held + returning) after this cycle's pop.
    assign occ_after_pop = {1'b0, stage_count} + {2'b00, rd_inflight} - {2'b00, pop};

    assign issue = (bram_count != '0) &&
                   (occ_after_pop < 3'(FIFO_OUT_STAGE_DEPTH));

`ifdef BRAM_FIFO_BYPASS_EN
    // Only when nothing older sits in BRAM or in flight, so order holds.
    assign bypass = accept && (bram_count == '0) && !rd_inflight &&
                    (occ_after_pop < 3'(FIFO_OUT_STAGE_DEPTH));
`else
    assign bypass = 1'b0;
`endif

    assign bram_we = accept && !bypass;

    // bypass requires no read in flight, so the two load sources never collide.
    assign load_valid = rd_inflight || bypass;
    assign load_data  = bypass ? in_data : bram_rdata;

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            bram_count  <= '0;
            rd_inflight <= 1'b0;
        end else begin
            if (bram_we) begin
                wr_ptr <= AW'(fifo_ptr_next(32'(wr_ptr), 32'(DEPTH)));
            end
            if (issue) begin
                rd_ptr <= AW'(fifo_ptr_next(32'(rd_ptr), 32'(DEPTH)));
            end
            bram_count  <= bram_count + BCW'(bram_we) - BCW'(issue);
            rd_inflight <= issue;
        end
    end

    bram_1r1w #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (WIDTH)
    ) u_bram (
        .clk   (clk),
        .we    (bram_we),
        .waddr (wr_ptr),
        .wdata (in_data),
        .re    (issue),
        .raddr (rd_ptr),
        .rdata (bram_rdata)
    );

    fifo_out_stage #(
        .WIDTH (WIDTH)
    ) u_out_stage (
        .clk         (clk),
        .reset       (reset),
        .load_valid  (load_valid),
        .load_data   (load_data),
        .pop         (pop),
        .valid       (out_valid),
        .data        (out_data),
        .stage_count (stage_count)
    );

    assign count = COUNT_WIDTH'(bram_count) + COUNT_WIDTH'(stage_count) +
                   COUNT_WIDTH'(rd_inflight);

    a_bram_count_bound: assert property (@(posedge clk) disable iff (!reset)
        bram_count <= BCW'(DEPTH));

    a_stage_bound: assert property (@(posedge clk) disable iff (!reset)
        ({1'b0, stage_count} + {2'b00, rd_inflight}) <= 3'd2);

endmodule

// File: tb/tb_bram_fifo_reader.sv
// Directed bench for bram_fifo_reader (WIDTH=8, DEPTH=16); honours
// BRAM_FIFO_BYPASS_EN for first-word latency expectations.
module tb_bram_fifo_reader;

`ifdef BRAM_FIFO_BYPASS_EN
    localparam logic BYP = 1'b1;
`else
    localparam logic BYP = 1'b0;
`endif

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic [4:0] count;

    int tests  = 0;
    int failed = 0;
    int pops   = 0;
    logic [7:0] exp_q[$];

    bram_fifo_reader #(.WIDTH(8), .DEPTH(16)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests++;
        assert (obs === expv) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Scoreboard the handshakes of the coming edge, advance one clock,
    // then compare occupancy with the model queue.
    task automatic cycle();
        if (out_valid === 1'b1 && out_ready) begin
            pops++;
            tests++;
            assert (exp_q.size() != 0) else begin
                failed++;
                $error("FAIL pop_underflow observed=pop expected=no_pop");
            end
            if (exp_q.size() != 0) check("pop_data", out_data, exp_q.pop_front());
        end
        if (in_valid && in_ready === 1'b1) exp_q.push_back(in_data);
        @(posedge clk);
        #1;
        check("count", count, exp_q.size());
    endtask

    initial begin
        int base_pops;
        logic [7:0] d;

        reset = 1'b0; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b0;

        // Reset then idle
        cycle(); cycle();
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cycle();
            check("idle_out_valid", out_valid, 0);
            check("idle_in_ready", in_ready, 1);
        end

        // Single word latency
        in_valid = 1'b1; in_data = 8'hA5;
        cycle();
        in_valid = 1'b0;
        check("lat_n", out_valid, BYP);
        cycle();
        check("lat_n1", out_valid, BYP);
        cycle();
        check("lat_n2", out_valid, 1);
        check("lat_data", out_data, 8'hA5);
        out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        check("single_empty", out_valid, 0);

        // Fill with consumer stalled: 18 words fit, extra pushes are ignored
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            in_data = (i < 18) ? 8'(i) : 8'hEE;
            check("fill_in_ready", in_ready, (i < 18) ? 1 : 0);
            cycle();
        end
        in_valid = 1'b0;
        check("full_count", count, 18);
        check("full_in_ready", in_ready, 0);
        check("full_head", out_data, 8'h00);
        out_ready = 1'b1;
        for (int i = 0; i < 25; i++) cycle();
        out_ready = 1'b0;
        check("fill_drained", exp_q.size(), 0);
        check("fill_in_ready_back", in_ready, 1);

        // Streaming at one word per cycle
        base_pops = pops;
        d = 8'h00;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            in_data = d;
            check("stream_in_ready", in_ready, 1);
            cycle();
            d = d + 8'd1;
        end
        check("stream_pops", pops - base_pops, BYP ? 99 : 97);
        in_valid = 1'b0;
        for (int i = 0; i < 6; i++) cycle();
        out_ready = 1'b0;
        check("stream_drained", exp_q.size(), 0);

        // Random backpressure
        for (int i = 0; i < 2000; i++) begin
            in_valid  = ($urandom_range(0, 99) < 30);
            in_data   = 8'($urandom_range(0, 255));
            out_ready = ($urandom_range(0, 1) == 1);
            cycle();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 40; i++) cycle();
        out_ready = 1'b0;
        check("rand_drained", exp_q.size(), 0);

        // Reset with 10 words held and a BRAM read in flight
        in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            in_data = 8'h40 + 8'(i);
            cycle();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        cycle();
        out_ready = 1'b0;
        check("pre_rst_count", count, 9);
        reset = 1'b0;
        exp_q.delete();
        cycle();
        reset = 1'b1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_in_ready", in_ready, 1);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("post_rst_no_stale", out_valid, 0);
        end
        in_valid = 1'b1; in_data = 8'h3C;
        cycle();
        in_valid = 1'b0;
        cycle(); cycle();
        check("post_rst_head", out_data, 8'h3C);
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        out_ready = 1'b0;
        check("post_rst_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
